// File: rtl/exec_sequencer.sv
// Issues up to three (load, select) micro-steps per decoded instruction, then retires it by pulsing eip_adv.
// Step k at accept+k, retire at accept+count+1; hold freezes the step. SEQ_RETIRE_CNT_EN adds retire_cnt.
module exec_sequencer #(
    parameter int CODE_W = 4,
    parameter int INC_W  = 4
) (
    input  logic              clk2,
    input  logic              reset,
    input  logic              ope_valid,
    output logic              ope_ready,
    input  logic [7:0]        opcode,
    input  logic [CODE_W-1:0] reg_load_1,
    input  logic [CODE_W-1:0] reg_load_2,
    input  logic [CODE_W-1:0] reg_load_3,
    input  logic [CODE_W-1:0] select_1,
    input  logic [CODE_W-1:0] select_2,
    input  logic [CODE_W-1:0] select_3,
    input  logic [INC_W-1:0]  num_of_ope,
    input  logic              hold,
    output logic              step_valid,
    output logic [CODE_W-1:0] step_load,
    output logic [CODE_W-1:0] step_sel,
    output logic [1:0]        step_idx,
    output logic              eip_adv,
    output logic [INC_W-1:0]  eip_inc,
    output logic              halted
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]       retire_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, STEP, RETIRE, HALT} state_t;

    localparam logic [CODE_W-1:0] EIP_CODE = CODE_W'(4);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        cnt_q;
    logic              br_q;
    logic [CODE_W-1:0] load1_q, load2_q, load3_q, sel1_q, sel2_q, sel3_q;
    logic [INC_W-1:0]  inc_q;
    logic              accept;
    logic [1:0]        dec_cnt;
    logic              dec_br;

    function automatic logic [1:0] step_count(input logic [7:0] op);
        case (op)
            8'hB8, 8'h89, 8'h83:                 return 2'd1;
            8'h55, 8'h5D, 8'hC3, 8'h6A, 8'h8B:   return 2'd2;
            8'hE2, 8'hE8, 8'hC9:                 return 2'd3;
            default:                             return 2'd0;
        endcase
    endfunction

    // Only steps that will actually issue may suppress the EIP advance.
    always_comb begin
        dec_cnt = step_count(opcode);
        dec_br  = ((dec_cnt >= 2'd1) && (reg_load_1 == EIP_CODE)) ||
                  ((dec_cnt >= 2'd2) && (reg_load_2 == EIP_CODE)) ||
                  ((dec_cnt == 2'd3) && (reg_load_3 == EIP_CODE));
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        accept     = 1'b0;
        ope_ready  = 1'b0;
        step_valid = 1'b0;
        step_load  = '0;
        step_sel   = '0;
        step_idx   = 2'd0;
        eip_adv    = 1'b0;
        eip_inc    = '0;
        halted     = 1'b0;
        case (state_q)
            IDLE: begin
                ope_ready = 1'b1;
                if (ope_valid) begin
                    accept = 1'b1;
                    if (dec_cnt != 2'd0) begin
                        state_d = STEP;
                        idx_d   = 2'd1;
                    end else begin
                        state_d = HALT;
                    end
                end
            end
            STEP: begin
                step_valid = 1'b1;
                step_idx   = idx_q;
                case (idx_q)
                    2'd2:    begin step_load = load2_q; step_sel = sel2_q; end
                    2'd3:    begin step_load = load3_q; step_sel = sel3_q; end
                    default: begin step_load = load1_q; step_sel = sel1_q; end
                endcase
                if (!hold) begin
                    if (idx_q == cnt_q) begin
                        state_d = RETIRE;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            RETIRE: begin
                eip_adv = ~br_q;
                eip_inc = br_q ? '0 : inc_q;
                state_d = IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk2) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 2'd0;
            br_q    <= 1'b0;
            load1_q <= '0;
            load2_q <= '0;
            load3_q <= '0;
            sel1_q  <= '0;
            sel2_q  <= '0;
            sel3_q  <= '0;
            inc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                cnt_q   <= dec_cnt;
                br_q    <= dec_br;
                load1_q <= reg_load_1;
                load2_q <= reg_load_2;
                load3_q <= reg_load_3;
                sel1_q  <= select_1;
                sel2_q  <= select_2;
                sel3_q  <= select_3;
                inc_q   <= num_of_ope;
            end
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt_q;

    always_ff @(posedge clk2) begin
        if (reset) begin
            retire_cnt_q <= 16'h0000;
        end else if (state_q == RETIRE) begin
            retire_cnt_q <= retire_cnt_q + 16'h0001;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: vector table through a per-cycle scoreboard, plus halt/reset/counter sequences.
module tb_exec_sequencer;

    logic       clk2 = 1'b0;
    logic       reset, ope_valid, ope_ready, hold;
    logic [7:0] opcode;
    logic [3:0] reg_load_1, reg_load_2, reg_load_3, select_1, select_2, select_3;
    logic [3:0] num_of_ope, step_load, step_sel, eip_inc;
    logic [1:0] step_idx;
    logic       step_valid, eip_adv, halted;
`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    always #5 clk2 = ~clk2;

    exec_sequencer #(.CODE_W(4), .INC_W(4)) dut (
        .clk2(clk2), .reset(reset), .ope_valid(ope_valid), .ope_ready(ope_ready),
        .opcode(opcode), .reg_load_1(reg_load_1), .reg_load_2(reg_load_2), .reg_load_3(reg_load_3),
        .select_1(select_1), .select_2(select_2), .select_3(select_3),
        .num_of_ope(num_of_ope), .hold(hold), .step_valid(step_valid),
        .step_load(step_load), .step_sel(step_sel), .step_idx(step_idx),
        .eip_adv(eip_adv), .eip_inc(eip_inc), .halted(halted)
`ifdef SEQ_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    typedef struct packed {
        logic       sv;
        logic [3:0] ld;
        logic [3:0] sl;
        logic [1:0] idx;
        logic       adv;
        logic [3:0] inc;
        logic       rdy;
        logic       hlt;
    } obs_t;

    typedef struct {
        logic [7:0] op;
        logic [3:0] l1, l2, l3, s1, s2, s3;
        logic [3:0] num;
        int         hold_n;
        int         cnt;
        bit         adv;
    } vec_t;

    obs_t        sbq[$];
    vec_t        vecs[12];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_rc = 16'h0000;

    function automatic obs_t mk_obs(input bit sv, input logic [3:0] ld, input logic [3:0] sl,
                                    input logic [1:0] idx, input bit adv, input logic [3:0] inc,
                                    input bit rdy, input bit hlt);
        obs_t o;
        o.sv = sv; o.ld = ld; o.sl = sl; o.idx = idx;
        o.adv = adv; o.inc = inc; o.rdy = rdy; o.hlt = hlt;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic [7:0] op,
                                    input logic [3:0] l1, input logic [3:0] l2, input logic [3:0] l3,
                                    input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                                    input logic [3:0] num, input int hold_n, input int cnt, input bit adv);
        vec_t v;
        v.op = op; v.l1 = l1; v.l2 = l2; v.l3 = l3;
        v.s1 = s1; v.s2 = s2; v.s3 = s3;
        v.num = num; v.hold_n = hold_n; v.cnt = cnt; v.adv = adv;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic check_obs(input string name, input obs_t e);
        obs_t a;
        a = mk_obs(step_valid, step_load, step_sel, step_idx, eip_adv, eip_inc, ope_ready, halted);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got sv=%b ld=%h sl=%h idx=%0d adv=%b inc=%h rdy=%b hlt=%b, want sv=%b ld=%h sl=%h idx=%0d adv=%b inc=%h rdy=%b hlt=%b",
                     name, a.sv, a.ld, a.sl, a.idx, a.adv, a.inc, a.rdy, a.hlt,
                     e.sv, e.ld, e.sl, e.idx, e.adv, e.inc, e.rdy, e.hlt);
        end
    endtask

`ifdef SEQ_RETIRE_CNT_EN
    task automatic check_rc(input string name);
        checks++;
        if (retire_cnt !== exp_rc) begin
            errors++;
            $display("FAIL %s: retire_cnt got %h want %h", name, retire_cnt, exp_rc);
        end
    endtask
`endif

    // Accept one instruction, then compare every following cycle against the scoreboard.
    task automatic run_vec(input vec_t v, input string name);
        logic [3:0] lds[3];
        logic [3:0] sls[3];
        int c;
        lds[0] = v.l1; lds[1] = v.l2; lds[2] = v.l3;
        sls[0] = v.s1; sls[1] = v.s2; sls[2] = v.s3;
        opcode = v.op; num_of_ope = v.num;
        reg_load_1 = v.l1; reg_load_2 = v.l2; reg_load_3 = v.l3;
        select_1 = v.s1; select_2 = v.s2; select_3 = v.s3;
        hold = 1'b0;
        ope_valid = 1'b1;
        tick();
        ope_valid = 1'b0;
        opcode = 8'($urandom); num_of_ope = 4'($urandom);
        reg_load_1 = 4'($urandom); reg_load_2 = 4'($urandom); reg_load_3 = 4'($urandom);
        select_1 = 4'($urandom); select_2 = 4'($urandom); select_3 = 4'($urandom);
        for (int k = 0; k < v.cnt; k++) begin
            for (int r = 0; r < ((k == 0) ? v.hold_n + 1 : 1); r++)
                sbq.push_back(mk_obs(1'b1, lds[k], sls[k], 2'(k + 1), 1'b0, 4'h0, 1'b0, 1'b0));
        end
        sbq.push_back(mk_obs(1'b0, 4'h0, 4'h0, 2'd0, v.adv, v.adv ? v.num : 4'h0, 1'b0, 1'b0));
        sbq.push_back(mk_obs(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1, 1'b0));
        c = 0;
        while (sbq.size() > 0) begin
            obs_t e;
            hold = (c < v.hold_n);
            e = sbq.pop_front();
            check_obs(name, e);
            c++;
            if (sbq.size() > 0) tick();
        end
        hold = 1'b0;
        exp_rc = exp_rc + 16'h0001;
`ifdef SEQ_RETIRE_CNT_EN
        check_rc({name, "_rc"});
`endif
    endtask

    initial begin
        obs_t idle_o, halt_o;
        idle_o = mk_obs(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1, 1'b0);
        halt_o = mk_obs(1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);

        vecs[0]  = mk_vec(8'h55, 4'h1, 4'h1, 4'h0, 4'h2, 4'h1, 4'h0, 4'h1, 0, 2, 1'b1);
        vecs[1]  = mk_vec(8'hB8, 4'h3, 4'bx, 4'bx, 4'h3, 4'bx, 4'bx, 4'h5, 3, 1, 1'b1);
        vecs[2]  = mk_vec(8'hE8, 4'h1, 4'h1, 4'h4, 4'h2, 4'h3, 4'h2, 4'h5, 0, 3, 1'b0);
        vecs[3]  = mk_vec(8'h89, 4'h2, 4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h2, 0, 1, 1'b1);
        vecs[4]  = mk_vec(8'h83, 4'h4, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h3, 0, 1, 1'b0);
        vecs[5]  = mk_vec(8'hB8, 4'h5, 4'h4, 4'h4, 4'h6, 4'h7, 4'h8, 4'h5, 0, 1, 1'b1);
        vecs[6]  = mk_vec(8'h5D, 4'h7, 4'h8, 4'h0, 4'h9, 4'hA, 4'h0, 4'h1, 1, 2, 1'b1);
        vecs[7]  = mk_vec(8'hC3, 4'h9, 4'h4, 4'h0, 4'h3, 4'h2, 4'h0, 4'h1, 0, 2, 1'b0);
        vecs[8]  = mk_vec(8'h6A, 4'hF, 4'hE, 4'h0, 4'hD, 4'hC, 4'h0, 4'h2, 2, 2, 1'b1);
        vecs[9]  = mk_vec(8'h8B, 4'h0, 4'h1, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 0, 2, 1'b1);
        vecs[10] = mk_vec(8'hE2, 4'hA, 4'hB, 4'h4, 4'h1, 4'h2, 4'h3, 4'h2, 2, 3, 1'b0);
        vecs[11] = mk_vec(8'hC9, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'h1, 0, 3, 1'b1);

        reset = 1'b1; ope_valid = 1'b0; hold = 1'b0; opcode = 8'h00; num_of_ope = 4'h0;
        reg_load_1 = 4'h0; reg_load_2 = 4'h0; reg_load_3 = 4'h0;
        select_1 = 4'h0; select_2 = 4'h0; select_3 = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        check_obs("reset_state", idle_o);
`ifdef SEQ_RETIRE_CNT_EN
        check_rc("reset_rc");
`endif
        hold = 1'b1;
        tick();
        check_obs("idle_hold_ignored", idle_o);
        hold = 1'b0;

        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_vec(vecs[i], nm);
        end

        // Illegal opcode: halt, ignore further requests, leave only through reset.
        opcode = 8'h90; ope_valid = 1'b1;
        tick();
        ope_valid = 1'b0;
        check_obs("illegal_halt", halt_o);
        opcode = 8'h55; reg_load_1 = 4'h1; select_1 = 4'h2; ope_valid = 1'b1; hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_obs("halt_ignores_valid", halt_o);
        end
`ifdef SEQ_RETIRE_CNT_EN
        check_rc("halt_rc_unchanged");
`endif
        ope_valid = 1'b0; hold = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rc = 16'h0000;
        check_obs("halt_reset_exit", idle_o);

        // Reset during step 2 of a three-step instruction: no retire may follow.
        opcode = 8'hC9; reg_load_1 = 4'h6; reg_load_2 = 4'h7; reg_load_3 = 4'h8;
        select_1 = 4'h9; select_2 = 4'hA; select_3 = 4'hB; num_of_ope = 4'h1;
        ope_valid = 1'b1;
        tick();
        ope_valid = 1'b0;
        check_obs("abort_step1", mk_obs(1'b1, 4'h6, 4'h9, 2'd1, 1'b0, 4'h0, 1'b0, 1'b0));
        tick();
        check_obs("abort_step2", mk_obs(1'b1, 4'h7, 4'hA, 2'd2, 1'b0, 4'h0, 1'b0, 1'b0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_obs("abort_reset", idle_o);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_obs("abort_no_retire", idle_o);
        end
`ifdef SEQ_RETIRE_CNT_EN
        check_rc("abort_rc");
`endif

        run_vec(vecs[0], "cnt_a");
        run_vec(vecs[7], "cnt_b");
        run_vec(vecs[2], "cnt_c");
`ifdef SEQ_RETIRE_CNT_EN
        force dut.retire_cnt_q = 16'hFFFF;
        #1;
        release dut.retire_cnt_q;
        exp_rc = 16'hFFFF;
        check_rc("rc_preload");
        run_vec(vecs[3], "rc_wrap");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
